// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage.
// Raw instruction words enter over a valid/ready handshake into a 2-entry
// buffer (in_ready is a flop). The head entry is decoded combinationally
// into R/I/J fields, a sign-extended immediate, destination register and
// branch / reg-write flags. Every decoded output is zero when out_valid=0.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  sync: drop buffered and incoming instructions
//   in_valid/in_ready/instr        upstream handshake + raw word
//   out_valid/out_ready            downstream handshake for the head entry
//   out_type (00 R, 01 I, 10 J), out_op, out_func, out_rs, out_rt,
//   out_dest, out_shamt, out_imm, out_branch, out_reg_write  decoded head
module decode_stage #(
  parameter int OPC_W    = 6,
  parameter int REG_AW   = 5,
  parameter int SHAMT_W  = 5,
  parameter int FUNC_W   = 6,
  parameter int DATA_W   = 32,
  parameter int JUMP_OPC = 1,
  parameter int BEQ_OPC  = 4,
  parameter int BNE_OPC  = 5,
  localparam int INSTR_W = OPC_W + 3*REG_AW + SHAMT_W + FUNC_W,
  localparam int IMM_W   = REG_AW + SHAMT_W + FUNC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_type,
  output logic [OPC_W-1:0]   out_op,
  output logic [FUNC_W-1:0]  out_func,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic [REG_AW-1:0]  out_dest,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_branch,
  output logic               out_reg_write
);

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_I = 2'b01;
  localparam logic [1:0] T_J = 2'b10;

  logic [1:0][INSTR_W-1:0] mem;
  logic                    head, tail;
  logic [1:0]              count, count_nxt;
  logic                    push, pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else if (flush) begin
      // A pop in this cycle was already consumed downstream; an incoming
      // word is simply not written.
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[tail] <= instr;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

  // Head-entry field slicing: op | rs | rt | rd | shamt | func
  logic [INSTR_W-1:0] h;
  logic [OPC_W-1:0]   f_op;
  logic [REG_AW-1:0]  f_rs, f_rt, f_rd;
  logic [SHAMT_W-1:0] f_shamt;
  logic [FUNC_W-1:0]  f_func;
  logic [IMM_W-1:0]   f_imm;
  logic [DATA_W-1:0]  imm_sx;
  logic               is_br;

  assign h       = mem[head];
  assign f_op    = h[INSTR_W-1 -: OPC_W];
  assign f_rs    = h[INSTR_W-OPC_W-1 -: REG_AW];
  assign f_rt    = h[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign f_rd    = h[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign f_shamt = h[FUNC_W +: SHAMT_W];
  assign f_func  = h[FUNC_W-1:0];
  assign f_imm   = h[IMM_W-1:0];
  assign imm_sx  = DATA_W'($signed(f_imm));
  assign is_br   = (f_op == OPC_W'(BEQ_OPC)) || (f_op == OPC_W'(BNE_OPC));

  always_comb begin
    out_type      = T_R;
    out_op        = '0;
    out_func      = '0;
    out_rs        = '0;
    out_rt        = '0;
    out_dest      = '0;
    out_shamt     = '0;
    out_imm       = '0;
    out_branch    = 1'b0;
    out_reg_write = 1'b0;
    if (out_valid) begin
      out_op = f_op;
      if (f_op == '0) begin
        out_type      = T_R;
        out_rs        = f_rs;
        out_rt        = f_rt;
        out_dest      = f_rd;
        out_shamt     = f_shamt;
        out_func      = f_func;
        out_reg_write = (f_rd != '0);
      end else if (f_op == OPC_W'(JUMP_OPC)) begin
        out_type   = T_J;
        out_imm    = imm_sx;
        out_branch = 1'b1;
      end else begin
        out_type      = T_I;
        out_rs        = f_rs;
        out_rt        = f_rt;
        // branches compare rs/rt and write nothing
        out_dest      = is_br ? '0 : f_rt;
        out_imm       = imm_sx;
        out_branch    = is_br;
        out_reg_write = !is_br && (f_rt != '0);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [1:0]  out_type;
  logic [5:0]  out_op, out_func;
  logic [4:0]  out_rs, out_rt, out_dest, out_shamt;
  logic [31:0] out_imm;
  logic        out_branch, out_reg_write;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_op(out_op), .out_func(out_func),
    .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
    .out_shamt(out_shamt), .out_imm(out_imm),
    .out_branch(out_branch), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [1:0]  typ;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        br;
    logic        rw;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"},  32'(out_valid),     32'(e.ov));
    chk({tag, ".type"},   32'(out_type),      32'(e.typ));
    chk({tag, ".op"},     32'(out_op),        32'(e.op));
    chk({tag, ".func"},   32'(out_func),      32'(e.func));
    chk({tag, ".rs"},     32'(out_rs),        32'(e.rs));
    chk({tag, ".rt"},     32'(out_rt),        32'(e.rt));
    chk({tag, ".dest"},   32'(out_dest),      32'(e.dest));
    chk({tag, ".shamt"},  32'(out_shamt),     32'(e.shamt));
    chk({tag, ".imm"},    out_imm,            e.imm);
    chk({tag, ".branch"}, 32'(out_branch),    32'(e.br));
    chk({tag, ".regwr"},  32'(out_reg_write), 32'(e.rw));
  endtask

  // Reference decode, straight from the instruction-format rules.
  function automatic exp_t ref_dec(input logic [31:0] w, input bit v);
    exp_t e;
    int   op, rs, rt, rd, sh, fn, imm;
    e = '{1'b0, 2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0};
    if (!v) return e;
    op  = int'(w / (1 << 26));
    rs  = int'((w / (1 << 21)) % 32);
    rt  = int'((w / (1 << 16)) % 32);
    rd  = int'((w / (1 << 11)) % 32);
    sh  = int'((w / (1 << 6)) % 32);
    fn  = int'(w % 64);
    imm = int'(w % 65536);
    if (imm >= 32768) imm = imm - 65536;
    e.ov = 1'b1;
    e.op = 6'(op);
    if (op == 0) begin
      e.typ = 2'd0; e.rs = 5'(rs); e.rt = 5'(rt); e.dest = 5'(rd);
      e.shamt = 5'(sh); e.func = 6'(fn); e.rw = (rd != 0);
    end else if (op == 1) begin
      e.typ = 2'd2; e.imm = 32'(imm); e.br = 1'b1;
    end else begin
      e.typ = 2'd1; e.rs = 5'(rs); e.rt = 5'(rt); e.imm = 32'(imm);
      e.br = (op == 4 || op == 5);
      e.dest = e.br ? 5'd0 : 5'(rt);
      e.rw = !e.br && (rt != 0);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  exp_t zero_e;
  vec_t tbl[10];

  initial begin
    logic [31:0] q[$];
    logic [31:0] seq[3];
    logic [31:0] w;
    bit          m_rdy, push, pop;

    zero_e = ref_dec(32'd0, 1'b0);
    //           instr          ov  typ    op     func   rs    rt     dest  shamt imm            br    rw
    tbl[0] = '{32'h012A4020, '{1'b1,2'd0,6'h00,6'h20,5'd9,5'd10,5'd8,5'd0,32'h00000000,1'b0,1'b1}};
    tbl[1] = '{32'h2128FFFC, '{1'b1,2'd1,6'h08,6'h00,5'd9,5'd8, 5'd8,5'd0,32'hFFFFFFFC,1'b0,1'b1}};
    tbl[2] = '{32'h11090003, '{1'b1,2'd1,6'h04,6'h00,5'd8,5'd9, 5'd0,5'd0,32'h00000003,1'b1,1'b0}};
    tbl[3] = '{32'h04008000, '{1'b1,2'd2,6'h01,6'h00,5'd0,5'd0, 5'd0,5'd0,32'hFFFF8000,1'b1,1'b0}};
    tbl[4] = '{32'h012A0020, '{1'b1,2'd0,6'h00,6'h20,5'd9,5'd10,5'd0,5'd0,32'h00000000,1'b0,1'b0}};
    tbl[5] = '{32'h00094100, '{1'b1,2'd0,6'h00,6'h00,5'd0,5'd9, 5'd8,5'd4,32'h00000000,1'b0,1'b1}};
    tbl[6] = '{32'h15090003, '{1'b1,2'd1,6'h05,6'h00,5'd8,5'd9, 5'd0,5'd0,32'h00000003,1'b1,1'b0}};
    tbl[7] = '{32'h34037FFF, '{1'b1,2'd1,6'h0D,6'h00,5'd0,5'd3, 5'd3,5'd0,32'h00007FFF,1'b0,1'b1}};
    tbl[8] = '{32'h20200005, '{1'b1,2'd1,6'h08,6'h00,5'd1,5'd0, 5'd0,5'd0,32'h00000005,1'b0,1'b0}};
    tbl[9] = '{32'h07FF8000, '{1'b1,2'd2,6'h01,6'h00,5'd0,5'd0, 5'd0,5'd0,32'hFFFF8000,1'b1,1'b0}};

    // ---- reset ----
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    step(); step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    check_out("rst", zero_e);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk("rst_rel.in_ready_pre_edge", 32'(in_ready), 32'd0);
    step();
    chk("rst_rel.in_ready", 32'(in_ready), 32'd1);

    // ---- table vectors: push one, check next cycle, let it drain ----
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; instr = tbl[i].instr;
      step();
      in_valid = 1'b0;
      check_out($sformatf("vec%0d", i), tbl[i].e);
      step();
      chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
    end

    // ---- backpressure: three back-to-back with out_ready low ----
    seq[0] = tbl[0].instr; seq[1] = tbl[2].instr; seq[2] = tbl[3].instr;
    out_ready = 1'b0;
    in_valid = 1'b1; instr = seq[0]; step();
    chk("bp.in_ready1", 32'(in_ready), 32'd1);
    instr = seq[1]; step();
    chk("bp.in_ready2", 32'(in_ready), 32'd0);
    check_out("bp.hold_a", ref_dec(seq[0], 1'b1));
    instr = seq[2]; step();
    chk("bp.in_ready3", 32'(in_ready), 32'd0);
    check_out("bp.hold_b", ref_dec(seq[0], 1'b1));
    out_ready = 1'b1; step();               // pop A, C still blocked
    check_out("bp.out1", ref_dec(seq[1], 1'b1));
    chk("bp.in_ready4", 32'(in_ready), 32'd1);
    step();                                  // pop B, push C
    in_valid = 1'b0;
    check_out("bp.out2", ref_dec(seq[2], 1'b1));
    step();                                  // pop C
    check_out("bp.empty", zero_e);

    // ---- flush with count=2 and a pending input ----
    out_ready = 1'b0;
    in_valid = 1'b1; instr = tbl[1].instr; step();
    instr = tbl[6].instr; step();
    instr = tbl[7].instr; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    check_out("flush", zero_e);
    out_ready = 1'b1; step();
    check_out("flush.after", zero_e);

    // ---- async reset mid-cycle with count=1 ----
    out_ready = 1'b0;
    in_valid = 1'b1; instr = tbl[5].instr; step();
    in_valid = 1'b0;
    check_out("arst.pre", tbl[5].e);
    #3 rst_n = 1'b0;
    #1 check_out("arst.now", zero_e);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    chk("arst.rel.in_ready", 32'(in_ready), 32'd1);
    check_out("arst.rel", zero_e);
    out_ready = 1'b1; in_valid = 1'b1; instr = tbl[0].instr; step();
    in_valid = 1'b0;
    check_out("arst.resume", tbl[0].e);
    step();

    // ---- randomized run against a queue model ----
    m_rdy = 1'b1;
    for (int c = 0; c < 600; c++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: w[31:26] = 6'd0;
        1: w[31:26] = 6'd1;
        2: w[31:26] = 6'd4;
        3: w[31:26] = 6'd5;
        default: ;
      endcase
      instr     = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      push = in_valid && m_rdy;
      pop  = (q.size() != 0) && out_ready;
      step();
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(w);
      end
      m_rdy = (q.size() < 2);
      chk($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(m_rdy));
      if (q.size() != 0) check_out($sformatf("rnd%0d", c), ref_dec(q[0], 1'b1));
      else check_out($sformatf("rnd%0d", c), zero_e);
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage. It sits between fetch and register-read/execute. It accepts raw instruction words over a valid/ready handshake and buffers them in a 2-entry skid buffer so that `in_ready` is a registered signal. It presents fully decoded fields (R/I/J type, sign-extended immediate, write-destination register, branch and reg-write flags) with deterministic values for every field and supports a pipeline flush.

Parameters:
- OPC_W, 6, opcode field width (instruction MSBs).
- REG_AW, 5, register-index width (rs, rt, rd fields).
- SHAMT_W, 5, shift-amount field width.
- FUNC_W, 6, function field width (instruction LSBs).
- DATA_W, 32, width of the sign-extended immediate output.
- JUMP_OPC, 1, opcode value decoded as J type.
- BEQ_OPC, 4, first I-type branch opcode.
- BNE_OPC, 5, second I-type branch opcode.
- Derived constant INSTR_W = OPC_W+3*REG_AW+SHAMT_W+FUNC_W (32 at defaults).
- Derived constant IMM_W = REG_AW+SHAMT_W+FUNC_W (16 at defaults). DATA_W >= IMM_W is required.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered and incoming instructions.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept; registered.
- instr  in  INSTR_W  raw instruction word.
- out_valid  out  1  decoded head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_type  out  2  00=R, 01=I, 10=J; 11 is never driven.
- out_op  out  OPC_W  opcode.
- out_func  out  FUNC_W  function code.
- out_rs  out  REG_AW  source register 1.
- out_rt  out  REG_AW  source register 2.
- out_dest  out  REG_AW  write-destination register.
- out_shamt  out  SHAMT_W  shift amount.
- out_imm  out  DATA_W  sign-extended immediate/address.
- out_branch  out  1  control-transfer instruction.
- out_reg_write  out  1  instruction writes the register file.

Behaviour:
- Field slicing, MSB to LSB: op | rs | rt | rd | shamt | func; imm = the low IMM_W bits.
- Storage:
  - 2-entry FIFO of raw instructions: head/tail pointers plus count 0..2.
  - Decode is combinational from the head entry only.
  - Outputs are held stable while `out_valid && !out_ready`.
- Handshake:
  - Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
  - `in_ready` is a registered signal equal to (count < 2) after the update.
  - `out_valid` = (count != 0).
- Latency: an instruction accepted in cycle N appears with `out_valid`=1 in cycle N+1. An empty stage does not pass through in the same cycle.
- Count boundary conditions:
  - count 1, push and pop together: count stays 1, new entry becomes head next cycle.
  - count 2: `in_ready`=0, so pop alone takes count to 1 and `in_ready` returns to 1 next cycle.
  - count 0, `out_ready` high: no pop, no effect.
  - Pointers wrap modulo 2.
- Decode rules:
  - R (op==0): type=00; rs, rt, rd, shamt, func taken from their fields; dest=rd; imm=0; branch=0; reg_write=(rd!=0).
  - J (op==JUMP_OPC): type=10; imm=sign-extended imm field; rs=rt=dest=shamt=func=0; branch=1; reg_write=0.
  - I (any other op): type=01; rs and rt taken from their fields; dest=rt; imm=sign-extended imm field; shamt=func=0.
    - branch=1 if op is BEQ_OPC or BNE_OPC; for those, dest is forced to 0.
    - reg_write=(!branch && rt!=0).
  - out_op always carries the opcode field.
- Idle outputs: when `out_valid`=0, every decoded output is 0 and out_type=00. No field ever retains a stale value.
- Flush:
  - Next edge: count=0, pointers=0, `out_valid`=0, `in_ready`=1.
  - An instruction presented in the flush cycle is dropped.
  - A pop in the flush cycle is still valid from the downstream side; nothing is re-presented.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, storage cleared to 0, `in_ready`=0 while `rst_n` is low.
  - `in_ready` rises to 1 on the first clock edge after `rst_n` deasserts.
  - All decoded outputs = 0, `out_valid`=0.

Test Plan:
- Reset then push R instr 0x012A4020 (add $8,$9,$10) with `out_ready`=1 -> next cycle: out_valid=1, type=00, rs=9, rt=10, dest=8, func=0x20, imm=0, branch=0, reg_write=1.
- Push I instr 0x2128FFFC (addi $8,$9,-4) -> type=01, rs=9, rt=8, dest=8, imm=0xFFFFFFFC, branch=0, reg_write=1. Push 0x11090003 (beq) -> branch=1, dest=0, reg_write=0, imm=3.
- Push J instr 0x04008000 -> type=10, imm=0xFFFF8000, rs=rt=dest=0, branch=1, reg_write=0; R instr with rd=0 -> reg_write=0.
- Hold `out_ready`=0 and push 3 back-to-back -> first two accepted, in_ready=0 on the third and it is held; outputs stable on the first. Raise out_ready -> all three emerge in order, none lost or duplicated.
- Count=2 plus a pending input, assert flush -> next cycle out_valid=0, in_ready=1, all outputs 0; the input presented during flush is never output.
- Assert `rst_n`=0 asynchronously mid-cycle with count=1 -> outputs go to 0 immediately, without waiting for a clock edge. After release, in_ready=1 on the first edge and the stage operates normally.
